// File: rtl/rtc_bus_sequencer_if.sv
// rtl/rtc_bus_sequencer_if.sv - request, result and RTC bus signals of the burst sequencer
interface rtc_bus_sequencer_if;
  logic       start;
  logic       rw;
  logic       crono;
  logic [7:0] wr_data;
  logic [3:0] wr_idx;
  logic [7:0] ad_in;
  logic [7:0] ad_out;
  logic       ad_oe;
  logic       cs_n;
  logic       rd_n;
  logic       wr_n;
  logic       ad_n;
  logic [7:0] rd_data;
  logic [3:0] rd_idx;
  logic       rd_valid;
  logic       busy;
  logic       done;

  modport master (
    input  start, rw, crono, wr_data, ad_in,
    output wr_idx, ad_out, ad_oe, cs_n, rd_n, wr_n, ad_n,
    output rd_data, rd_idx, rd_valid, busy, done
  );

  modport slave (
    output start, rw, crono, wr_data, ad_in,
    input  wr_idx, ad_out, ad_oe, cs_n, rd_n, wr_n, ad_n,
    input  rd_data, rd_idx, rd_valid, busy, done
  );
endinterface

// File: rtl/rtc_bus_sequencer.sv
// rtl/rtc_bus_sequencer.sv - burst of register accesses to the RTC over a multiplexed 8-bit bus
// Each access walks seven equal-length phases; every output is a flop loaded from next-state decode.
module rtc_bus_sequencer #(
  parameter int unsigned T_PHASE    = 10,
  parameter logic [7:0]  TIME_BASE  = 8'h21,
  parameter logic [7:0]  CRONO_BASE = 8'h41
) (
  input logic                 clk,
  input logic                 Reset,
  rtc_bus_sequencer_if.master bus
);
  localparam int unsigned   PW      = $clog2(T_PHASE);
  localparam logic [PW-1:0] PH_LAST = PW'(T_PHASE - 1);

  typedef enum logic [3:0] {
    S_IDLE, S_A_SET, S_A_STB, S_A_HLD, S_D_SET, S_D_STB, S_D_HLD, S_GAP, S_DONE
  } state_t;

  state_t        state_q, state_d;
  logic [PW-1:0] phase_q, phase_d;
  logic [3:0]    idx_q, idx_d;
  logic [3:0]    last_idx_q, last_idx_d;
  logic [7:0]    base_q, base_d;
  logic          rw_q, rw_d;
  logic          start_prev_q, start_prev_d;
  logic [7:0]    ad_out_q, ad_out_d;
  logic          ad_oe_q, ad_oe_d;
  logic          cs_n_q, cs_n_d;
  logic          rd_n_q, rd_n_d;
  logic          wr_n_q, wr_n_d;
  logic          ad_n_q, ad_n_d;
  logic [7:0]    rd_data_q, rd_data_d;
  logic [3:0]    rd_idx_q, rd_idx_d;
  logic          rd_valid_q, rd_valid_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic [7:0]    addr;

  always_comb begin
    state_d      = state_q;
    phase_d      = phase_q;
    idx_d        = idx_q;
    last_idx_d   = last_idx_q;
    base_d       = base_q;
    rw_d         = rw_q;
    start_prev_d = bus.start;

    case (state_q)
      S_IDLE: begin
        if (bus.start && !start_prev_q) begin
          rw_d       = bus.rw;
          base_d     = bus.crono ? CRONO_BASE : TIME_BASE;
          last_idx_d = bus.crono ? 4'd2 : 4'd5;
          idx_d      = 4'd0;
          phase_d    = '0;
          state_d    = S_A_SET;
        end
      end
      S_DONE: begin
        idx_d   = 4'd0;
        state_d = S_IDLE;
      end
      S_A_SET, S_A_STB, S_A_HLD, S_D_SET, S_D_STB, S_D_HLD, S_GAP: begin
        if (phase_q == PH_LAST) begin
          phase_d = '0;
          case (state_q)
            S_A_SET: state_d = S_A_STB;
            S_A_STB: state_d = S_A_HLD;
            S_A_HLD: state_d = S_D_SET;
            S_D_SET: state_d = S_D_STB;
            S_D_STB: state_d = S_D_HLD;
            S_D_HLD: state_d = S_GAP;
            default: begin
              if (idx_q == last_idx_q) begin
                state_d = S_DONE;
              end else begin
                idx_d   = idx_q + 4'd1;
                state_d = S_A_SET;
              end
            end
          endcase
        end else begin
          phase_d = phase_q + PW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Output flops are loaded from the state being entered so they line up with state_q.
    addr       = base_d + {4'b0000, idx_d};
    ad_out_d   = 8'h00;
    ad_oe_d    = 1'b0;
    cs_n_d     = 1'b1;
    rd_n_d     = 1'b1;
    wr_n_d     = 1'b1;
    ad_n_d     = 1'b1;
    busy_d     = 1'b0;
    done_d     = 1'b0;
    rd_valid_d = 1'b0;
    rd_data_d  = rd_data_q;
    rd_idx_d   = rd_idx_q;

    case (state_d)
      S_A_SET, S_A_STB, S_A_HLD: begin
        cs_n_d   = 1'b0;
        ad_n_d   = 1'b0;
        ad_oe_d  = 1'b1;
        ad_out_d = addr;
        busy_d   = 1'b1;
        wr_n_d   = (state_d != S_A_STB);
      end
      S_D_SET, S_D_STB, S_D_HLD: begin
        cs_n_d  = 1'b0;
        busy_d  = 1'b1;
        ad_oe_d = !rw_d;
        if (!rw_d) begin
          ad_out_d = (state_q == S_A_HLD) ? bus.wr_data : ad_out_q;
        end
        if (state_d == S_D_STB) begin
          rd_n_d = !rw_d;
          wr_n_d = rw_d;
        end
      end
      S_GAP:   busy_d = 1'b1;
      S_DONE:  done_d = 1'b1;
      default: busy_d = 1'b0;
    endcase

    // ad_in is captured on the edge that ends the read strobe.
    if (rw_q && state_q == S_D_STB && state_d == S_D_HLD) begin
      rd_valid_d = 1'b1;
      rd_data_d  = bus.ad_in;
      rd_idx_d   = idx_q;
    end
  end

  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      state_q      <= S_IDLE;
      phase_q      <= '0;
      idx_q        <= 4'd0;
      last_idx_q   <= 4'd0;
      base_q       <= 8'h00;
      rw_q         <= 1'b0;
      start_prev_q <= 1'b0;
      ad_out_q     <= 8'h00;
      ad_oe_q      <= 1'b0;
      cs_n_q       <= 1'b1;
      rd_n_q       <= 1'b1;
      wr_n_q       <= 1'b1;
      ad_n_q       <= 1'b1;
      rd_data_q    <= 8'h00;
      rd_idx_q     <= 4'd0;
      rd_valid_q   <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      phase_q      <= phase_d;
      idx_q        <= idx_d;
      last_idx_q   <= last_idx_d;
      base_q       <= base_d;
      rw_q         <= rw_d;
      start_prev_q <= start_prev_d;
      ad_out_q     <= ad_out_d;
      ad_oe_q      <= ad_oe_d;
      cs_n_q       <= cs_n_d;
      rd_n_q       <= rd_n_d;
      wr_n_q       <= wr_n_d;
      ad_n_q       <= ad_n_d;
      rd_data_q    <= rd_data_d;
      rd_idx_q     <= rd_idx_d;
      rd_valid_q   <= rd_valid_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  assign bus.wr_idx   = idx_q;
  assign bus.ad_out   = ad_out_q;
  assign bus.ad_oe    = ad_oe_q;
  assign bus.cs_n     = cs_n_q;
  assign bus.rd_n     = rd_n_q;
  assign bus.wr_n     = wr_n_q;
  assign bus.ad_n     = ad_n_q;
  assign bus.rd_data  = rd_data_q;
  assign bus.rd_idx   = rd_idx_q;
  assign bus.rd_valid = rd_valid_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
endmodule

// File: tb/tb_rtc_bus_sequencer.sv
// tb/tb_rtc_bus_sequencer.sv - directed bench for rtc_bus_sequencer at T_PHASE 10 and 2
module tb_rtc_bus_sequencer;
  logic clk = 1'b0;
  logic Reset;
  always #5 clk = ~clk;

  rtc_bus_sequencer_if ia ();
  rtc_bus_sequencer_if ib ();

  rtc_bus_sequencer #(.T_PHASE(10)) dut_a (.clk(clk), .Reset(Reset), .bus(ia));
  rtc_bus_sequencer #(.T_PHASE(2))  dut_b (.clk(clk), .Reset(Reset), .bus(ib));

  int checks = 0;
  int failures = 0;
  int sel = 0;
  int tp = 10;
  int cyc = 0;
  int launch_cyc, done_cyc;

  logic       o_cs_n, o_rd_n, o_wr_n, o_ad_n, o_ad_oe, o_rd_valid, o_busy, o_done;
  logic [7:0] o_ad_out, o_rd_data;
  logic [3:0] o_rd_idx, o_wr_idx;

  always_comb begin
    o_cs_n     = sel ? ib.cs_n     : ia.cs_n;
    o_rd_n     = sel ? ib.rd_n     : ia.rd_n;
    o_wr_n     = sel ? ib.wr_n     : ia.wr_n;
    o_ad_n     = sel ? ib.ad_n     : ia.ad_n;
    o_ad_oe    = sel ? ib.ad_oe    : ia.ad_oe;
    o_ad_out   = sel ? ib.ad_out   : ia.ad_out;
    o_rd_valid = sel ? ib.rd_valid : ia.rd_valid;
    o_rd_data  = sel ? ib.rd_data  : ia.rd_data;
    o_rd_idx   = sel ? ib.rd_idx   : ia.rd_idx;
    o_wr_idx   = sel ? ib.wr_idx   : ia.wr_idx;
    o_busy     = sel ? ib.busy     : ia.busy;
    o_done     = sel ? ib.done     : ia.done;
  end

  int done_cnt, rdv_cnt, rd_low, both_low, oe_rd, cs_bad, adn_bad, stb_bad, gap_bad, acc_cnt, done_busy;
  int cs_run, adl_run, wr_run, rd_run, gap_run, wa_n, wd_n;
  logic       p_cs_n, p_ad_n, p_wr_n, p_rd_n;
  logic [7:0] rdv_data [6];
  logic [3:0] rdv_idx [6];
  logic [7:0] wa [6];
  logic [7:0] wd [6];
  logic [7:0] latched_addr = 8'h00;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_stats();
    done_cnt = 0; rdv_cnt = 0; rd_low = 0; both_low = 0; oe_rd = 0; cs_bad = 0; adn_bad = 0;
    stb_bad = 0; gap_bad = 0; acc_cnt = 0; done_busy = 0; cs_run = 0; adl_run = 0; wr_run = 0;
    rd_run = 0; gap_run = 0; wa_n = 0; wd_n = 0;
    p_cs_n = o_cs_n; p_ad_n = o_ad_n; p_wr_n = o_wr_n; p_rd_n = o_rd_n;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (!o_rd_n && !o_wr_n) both_low++;
    if (!o_rd_n && o_ad_oe) oe_rd++;
    if (!o_rd_n) rd_low++;
    if (o_cs_n) begin
      if (!p_cs_n) begin
        if (cs_run != 6 * tp) cs_bad++;
        cs_run = 0;
        gap_run = 0;
      end
      gap_run++;
      if (!o_ad_n) adn_bad++;
    end else begin
      if (p_cs_n) begin
        acc_cnt++;
        if (acc_cnt > 1 && gap_run != tp) gap_bad++;
      end
      cs_run++;
      if (!p_cs_n && p_ad_n && !o_ad_n) adn_bad++;
    end
    if (!o_ad_n) adl_run++;
    else if (!p_ad_n) begin
      if (adl_run != 3 * tp) adn_bad++;
      adl_run = 0;
    end
    if (!o_wr_n) begin
      wr_run++;
      if (p_wr_n) begin
        if (!o_ad_n) begin
          latched_addr = o_ad_out;
          if (wa_n < 6) wa[wa_n] = o_ad_out;
          wa_n++;
        end else begin
          if (wd_n < 6) wd[wd_n] = o_ad_out;
          wd_n++;
        end
      end
    end else if (!p_wr_n) begin
      if (wr_run != tp) stb_bad++;
      wr_run = 0;
    end
    if (!o_rd_n) rd_run++;
    else if (!p_rd_n) begin
      if (rd_run != tp) stb_bad++;
      rd_run = 0;
    end
    if (o_rd_valid) begin
      if (rdv_cnt < 6) begin
        rdv_data[rdv_cnt] = o_rd_data;
        rdv_idx[rdv_cnt]  = o_rd_idx;
      end
      rdv_cnt++;
    end
    if (o_done) begin
      done_cnt++;
      done_cyc = cyc;
      if (o_busy) done_busy++;
    end
    p_cs_n = o_cs_n; p_ad_n = o_ad_n; p_wr_n = o_wr_n; p_rd_n = o_rd_n;
    ia.ad_in   = 8'h10 + latched_addr;
    ib.ad_in   = 8'h10 + latched_addr;
    ia.wr_data = 8'hA0 + {4'h0, ia.wr_idx};
    ib.wr_data = 8'hA0 + {4'h0, ib.wr_idx};
  endtask

  task automatic launch(input logic r, input logic c);
    if (sel == 0) begin ia.rw = r; ia.crono = c; ia.start = 1'b1; end
    else begin ib.rw = r; ib.crono = c; ib.start = 1'b1; end
    launch_cyc = cyc;
  endtask

  task automatic wait_done(input int budget);
    int n0;
    n0 = done_cnt;
    for (int i = 0; i < budget; i++) begin
      tick();
      if (done_cnt != n0) break;
    end
    chk("done_reached", done_cnt != n0, 1);
  endtask

  task automatic chk_timing(input string tag);
    chk({tag, "_cs_len"}, cs_bad, 0);
    chk({tag, "_ad_n"}, adn_bad, 0);
    chk({tag, "_strobe_len"}, stb_bad, 0);
    chk({tag, "_gap_len"}, gap_bad, 0);
    chk({tag, "_both_strobes"}, both_low, 0);
    chk({tag, "_oe_during_rd"}, oe_rd, 0);
    chk({tag, "_busy_in_done"}, done_busy, 0);
  endtask

  initial begin
    Reset = 1'b1;
    ia.start = 0; ia.rw = 0; ia.crono = 0; ia.wr_data = 0; ia.ad_in = 0;
    ib.start = 0; ib.rw = 0; ib.crono = 0; ib.wr_data = 0; ib.ad_in = 0;
    repeat (2) @(posedge clk);
    #1 Reset = 1'b0;
    clear_stats();
    tick();

    chk("rst_cs_n", o_cs_n, 1);
    chk("rst_strobes", {o_rd_n, o_wr_n, o_ad_n}, 3'b111);
    chk("rst_ad_oe", o_ad_oe, 0);
    chk("rst_ad_out", o_ad_out, 8'h00);
    chk("rst_rd", {o_rd_data, o_rd_idx, o_rd_valid}, 13'h0);
    chk("rst_busy_done_idx", {o_busy, o_done, o_wr_idx}, 6'h0);

    // Read burst, time bank, T_PHASE=10
    clear_stats();
    launch(1'b1, 1'b0);
    tick();
    ia.start = 1'b0;
    chk("rd10_first_busy", o_busy, 1);
    chk("rd10_first_addr", {o_cs_n, o_ad_n, o_ad_oe, o_ad_out}, {3'b001, 8'h21});
    wait_done(500);
    chk("rd10_latency", done_cyc - launch_cyc, 421);
    chk("rd10_valid_cnt", rdv_cnt, 6);
    chk("rd10_acc_cnt", acc_cnt, 6);
    for (int i = 0; i < 6; i++) begin
      chk("rd10_data", rdv_data[i], 8'h31 + i);
      chk("rd10_idx", rdv_idx[i], i);
      chk("rd10_addr", wa[i], 8'h21 + i);
    end
    chk_timing("rd10");
    tick();
    chk("rd10_idle", {o_busy, o_done, o_wr_idx, o_cs_n}, 7'b0000001);

    // Write burst, timer bank
    clear_stats();
    launch(1'b0, 1'b1);
    tick();
    ia.start = 1'b0;
    wait_done(300);
    chk("wr10_latency", done_cyc - launch_cyc, 211);
    chk("wr10_acc_cnt", acc_cnt, 3);
    chk("wr10_addr_cnt", wa_n, 3);
    chk("wr10_data_cnt", wd_n, 3);
    for (int i = 0; i < 3; i++) begin
      chk("wr10_addr", wa[i], 8'h41 + i);
      chk("wr10_data", wd[i], 8'hA0 + i);
    end
    chk("wr10_rd_n_low", rd_low, 0);
    chk("wr10_no_rdv", rdv_cnt, 0);
    chk_timing("wr10");

    // start held high with an extra pulse mid-burst
    tick();
    clear_stats();
    launch(1'b1, 1'b0);
    repeat (200) tick();
    ia.start = 1'b0;
    tick();
    ia.start = 1'b1;
    wait_done(400);
    repeat (30) tick();
    chk("hold_done_cnt", done_cnt, 1);
    chk("hold_acc_cnt", acc_cnt, 6);
    chk("hold_idle", o_busy, 0);
    ia.start = 1'b0;
    tick();
    ia.start = 1'b1;
    tick();
    chk("hold_relaunch", o_busy, 1);
    ia.start = 1'b0;
    wait_done(500);
    chk("hold_done_cnt2", done_cnt, 2);

    // Reset during D_STB of a write
    tick();
    clear_stats();
    launch(1'b0, 1'b0);
    tick();
    ia.start = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (!o_wr_n && o_ad_n) break;
      tick();
    end
    chk("rst_mid_found_dstb", {o_wr_n, o_ad_n}, 2'b01);
    #3 Reset = 1'b1;
    #1;
    chk("rst_mid_release", {o_wr_n, o_cs_n, o_ad_oe, o_busy, o_done}, 5'b11000);
    #1 Reset = 1'b0;
    clear_stats();
    repeat (100) tick();
    chk("rst_mid_no_done", done_cnt, 0);
    chk("rst_mid_idle", {o_busy, o_cs_n}, 2'b01);

    // T_PHASE=2 read burst, then a start edge landing in the DONE cycle
    sel = 1;
    tp = 2;
    clear_stats();
    launch(1'b1, 1'b0);
    tick();
    ib.start = 1'b0;
    wait_done(200);
    chk("rd2_latency", done_cyc - launch_cyc, 85);
    chk("rd2_valid_cnt", rdv_cnt, 6);
    for (int i = 0; i < 6; i++) chk("rd2_data", rdv_data[i], 8'h31 + i);
    chk_timing("rd2");
    ib.start = 1'b1;
    tick();
    tick();
    chk("rd2_done_edge_ignored", {o_busy, o_cs_n}, 2'b01);
    ib.start = 1'b0;
    tick();

    clear_stats();
    launch(1'b0, 1'b1);
    tick();
    ib.start = 1'b0;
    wait_done(100);
    chk("wr2_latency", done_cyc - launch_cyc, 43);
    chk("wr2_data_cnt", wd_n, 3);
    for (int i = 0; i < 3; i++) begin
      chk("wr2_addr", wa[i], 8'h41 + i);
      chk("wr2_data", wd[i], 8'hA0 + i);
    end
    chk_timing("wr2");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
